// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: sequences MEM-stage loads/stores onto the req/addr_ok/data_ok data SRAM bus,
// with alignment checks, store byte shaping, load extension, flush draining and a request timeout.
module dm_access_ctrl #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic [2:0]  load_store_mem,
    input  logic [31:0] addr_mem,
    input  logic [31:0] rdata2_mem,
    input  logic        flush,
    input  logic        wb_allowin,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] load_result,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    state_t state, state_n;
    logic [2:0]  op;
    logic [1:0]  sft;
    logic [31:0] cnt;
    logic [31:0] shifted;
    logic [31:0] ext;
    logic [3:0]  strb;
    logic        accept, is_store, half, word, misaligned, timeout;

    always_comb begin
        accept     = (state == IDLE) & mem_req & ~flush;
        is_store   = load_store_mem[2] & (load_store_mem[1] | load_store_mem[0]);
        half       = load_store_mem inside {3'b010, 3'b011, 3'b110};
        word       = load_store_mem inside {3'b100, 3'b111};
        misaligned = (half & addr_mem[0]) | (word & |addr_mem[1:0]);
        strb       = load_store_mem == 3'b101 ? 4'b0001 << addr_mem[1:0] :
                     load_store_mem == 3'b110 ? 4'b0011 << addr_mem[1:0] :
                     load_store_mem == 3'b111 ? 4'b1111 : 4'b0000;
        shifted    = data_sram_rdata >> {sft, 3'b000};
        ext        = op == 3'b000 ? {{24{shifted[7]}}, shifted[7:0]} :
                     op == 3'b001 ? {24'b0, shifted[7:0]} :
                     op == 3'b010 ? {{16{shifted[15]}}, shifted[15:0]} :
                     op == 3'b011 ? {16'b0, shifted[15:0]} :
                     op == 3'b100 ? shifted : 32'b0;
        timeout    = (MAX_WAIT != 0) && (cnt + 32'd1 >= MAX_WAIT);
        state_n    = state;
        case (state)
            IDLE:  if (accept) state_n = misaligned ? DONE : REQ;
            REQ:   state_n = flush ? (data_sram_addr_ok ? DRAIN : IDLE) :
                             data_sram_addr_ok ? WAIT : timeout ? DONE : REQ;
            // a flush that coincides with data_ok has nothing left to drain
            WAIT:  state_n = flush ? (data_sram_data_ok ? IDLE : DRAIN) :
                             (data_sram_data_ok | timeout) ? DONE : WAIT;
            DONE:  if (flush | wb_allowin) state_n = IDLE;
            DRAIN: if (data_sram_data_ok) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        mem_done      = state == DONE;
        data_sram_req = state == REQ;
        mem_stall     = accept | (state == REQ) | (state == WAIT) | (state == DRAIN) |
                        ((state == DONE) & ~wb_allowin);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op              <= '0;
            sft             <= '0;
            data_sram_wr    <= 1'b0;
            data_sram_wstrb <= '0;
            data_sram_addr  <= '0;
            data_sram_wdata <= '0;
            load_result     <= '0;
            adel            <= 1'b0;
            ades            <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= accept ? 32'd0 : (state == REQ || state == WAIT) ? cnt + 32'd1 : cnt;
            if (accept) begin
                op              <= load_store_mem;
                sft             <= addr_mem[1:0];
                data_sram_wr    <= is_store;
                data_sram_wstrb <= strb;
                data_sram_addr  <= addr_mem;
                data_sram_wdata <= rdata2_mem << {addr_mem[1:0], 3'b000};
                load_result     <= '0;
                adel            <= misaligned & ~is_store;
                ades            <= misaligned & is_store;
            end
            if (state == WAIT && !flush && data_sram_data_ok)
                load_result <= ext;
            if ((state == REQ || (state == WAIT && !data_sram_data_ok)) && state_n == DONE)
                bus_err <= 1'b1;
            if (state == DONE && state_n == IDLE) begin
                load_result <= '0;
                adel        <= 1'b0;
                ades        <= 1'b0;
                bus_err     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and randomized checks of dm_access_ctrl against a byte-level model,
// with a bench-side bus responder; the DUT runs with a short timeout of 4 cycles.
module tb_dm_access_ctrl;
    logic        clk = 0, rst = 0;
    logic        mem_req = 0, flush = 0, wb_allowin = 1;
    logic [2:0]  load_store_mem = 0;
    logic [31:0] addr_mem = 0, rdata2_mem = 0, data_sram_rdata = 0;
    logic        data_sram_addr_ok = 0, data_sram_data_ok = 0;
    logic        mem_stall, mem_done, adel, ades, bus_err;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] load_result, data_sram_addr, data_sram_wdata;

    int checks = 0, errors = 0;
    int o_lat, o_nreq;
    logic [3:0]  o_strb;
    logic [31:0] o_wdata, o_addr, o_res;
    logic        o_wr, o_adel, o_ades, o_berr;

    dm_access_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .load_store_mem(load_store_mem),
        .addr_mem(addr_mem), .rdata2_mem(rdata2_mem), .flush(flush), .wb_allowin(wb_allowin),
        .mem_stall(mem_stall), .mem_done(mem_done), .load_result(load_result),
        .adel(adel), .ades(ades), .bus_err(bus_err), .data_sram_req(data_sram_req),
        .data_sram_wr(data_sram_wr), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata)
    );

    always #5 clk = ~clk;

    // Presents one op, plays the bus slave (addr_ok on the da+1-th req cycle, data_ok dd cycles later)
    // and records what the DUT showed; o_lat is the cycle of mem_done counted from the accept cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, wd, rd, input int da, dd);
        int dcnt;
        @(negedge clk);
        mem_req = 1; load_store_mem = op; addr_mem = a; rdata2_mem = wd; data_sram_rdata = rd;
        wb_allowin = 1;
        o_nreq = 0; o_lat = -1; dcnt = 0; o_wr = 0; o_strb = 0; o_wdata = 0; o_addr = 0;
        for (int c = 1; c <= 20 && o_lat < 0; c++) begin
            @(negedge clk);
            data_sram_addr_ok = 0; data_sram_data_ok = 0;
            if (mem_done) begin
                o_lat = c; o_res = load_result; o_adel = adel; o_ades = ades; o_berr = bus_err;
                mem_req = 0;
            end else if (data_sram_req) begin
                o_nreq++;
                o_wr = data_sram_wr; o_strb = data_sram_wstrb; o_wdata = data_sram_wdata;
                o_addr = data_sram_addr;
                if (o_nreq == da + 1) begin data_sram_addr_ok = 1; dcnt = dd; end
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) data_sram_data_ok = 1;
            end
        end
        mem_req = 0;
        if (o_lat < 0) begin
            checks++; errors++;
            $display("FAIL op_completion: mem_done never seen for op %0d addr %h", op, a);
        end
    endtask

    task automatic test_reset;
        rst = 0; #1 rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_stall, mem_done, load_result, adel, ades, bus_err, data_sram_req, data_sram_wr,
             data_sram_wstrb, data_sram_addr, data_sram_wdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: req=%b stall=%b done=%b addr=%h", data_sram_req,
                               mem_stall, mem_done, data_sram_addr);
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({mem_stall, mem_done, data_sram_req} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset: stall/done/req=%b want 000",
                               {mem_stall, mem_done, data_sram_req});
        end
    endtask

    task automatic test_store_shaping;
        do_op(3'b111, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1);
        checks++;
        if ({o_lat, o_nreq, o_wr, o_strb, o_wdata, o_addr} !== {32'd3, 32'd1, 1'b1, 4'b1111,
             32'hDEAD_BEEF, 32'h1000_0004}) begin
            errors++; $display("FAIL sw: lat=%0d nreq=%0d wr=%b strb=%b wdata=%h addr=%h want 3 1 1 1111 deadbeef 10000004",
                               o_lat, o_nreq, o_wr, o_strb, o_wdata, o_addr);
        end
        do_op(3'b101, 32'h1000_0003, 32'h0000_00A5, 32'h0, 0, 1);
        checks++;
        if ({o_strb, o_wdata} !== {4'b1000, 32'hA500_0000}) begin
            errors++; $display("FAIL sb: strb=%b wdata=%h want 1000 a5000000", o_strb, o_wdata);
        end
        do_op(3'b110, 32'h1000_0002, 32'h1234_BEEF, 32'h0, 1, 2);
        checks++;
        if ({o_strb, o_wdata, o_res, o_lat} !== {4'b1100, 32'hBEEF_0000, 32'h0, 32'd5}) begin
            errors++; $display("FAIL sh: strb=%b wdata=%h res=%h lat=%0d want 1100 beef0000 0 5",
                               o_strb, o_wdata, o_res, o_lat);
        end
    endtask

    task automatic test_load_extract;
        do_op(3'b000, 32'h2000_0001, 32'h0, 32'h1234_80FF, 0, 1);
        checks++;
        if ({o_res, o_wr, o_strb} !== {32'hFFFF_FF80, 1'b0, 4'b0000}) begin
            errors++; $display("FAIL lb: res=%h wr=%b strb=%b want ffffff80 0 0000", o_res, o_wr, o_strb);
        end
        do_op(3'b001, 32'h2000_0001, 32'h0, 32'h1234_80FF, 0, 1);
        checks++;
        if (o_res !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu: res=%h want 00000080", o_res);
        end
        do_op(3'b011, 32'h2000_0002, 32'h0, 32'h1234_80FF, 0, 1);
        checks++;
        if (o_res !== 32'h0000_1234) begin
            errors++; $display("FAIL lhu: res=%h want 00001234", o_res);
        end
    endtask

    task automatic test_misaligned;
        do_op(3'b100, 32'h3000_0002, 32'h0, 32'h0, 0, 1);
        checks++;
        if ({o_adel, o_ades, o_lat, o_nreq} !== {1'b1, 1'b0, 32'd1, 32'd0}) begin
            errors++; $display("FAIL lw_misaligned: adel=%b ades=%b lat=%0d nreq=%0d want 1 0 1 0",
                               o_adel, o_ades, o_lat, o_nreq);
        end
        do_op(3'b110, 32'h3000_0001, 32'h0, 32'h0, 0, 1);
        checks++;
        if ({o_adel, o_ades, o_nreq} !== {1'b0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL sh_misaligned: adel=%b ades=%b nreq=%0d want 0 1 0",
                               o_adel, o_ades, o_nreq);
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, wd, rd, e_strb, e_wdata, e_res;
        longint v;
        int size, s, da, dd;
        bit st, mis;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom; rd = $urandom;
            da = $urandom_range(0, 1); dd = $urandom_range(1, 2);
            size = (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
            s = int'(a % 4); mis = (a % size) != 0; st = op >= 5;
            e_strb = st ? ((((32'd1 << size) - 1) << s) & 32'hF) : 32'h0;
            e_wdata = wd << (8 * s);
            v = longint'(rd) >> (8 * s);
            v = v % (longint'(1) << (8 * size));
            if ((op == 0 || op == 2) && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            e_res = (st || mis) ? 32'h0 : 32'(v);
            do_op(op, a, wd, rd, da, dd);
            checks++;
            if (mis) begin
                if ({o_lat, o_nreq, o_adel, o_ades} !== {32'd1, 32'd0, !st, st}) begin
                    errors++; $display("FAIL rand_misaligned[%0d]: op=%0d a=%h lat=%0d nreq=%0d adel=%b ades=%b",
                                       i, op, a, o_lat, o_nreq, o_adel, o_ades);
                end
            end else if (o_lat != da + dd + 2 || o_nreq != da + 1 || o_wr !== st ||
                         o_strb !== e_strb[3:0] || o_addr !== a || (st && o_wdata !== e_wdata) ||
                         o_res !== e_res || {o_adel, o_ades, o_berr} !== 3'b000) begin
                errors++; $display("FAIL rand_op[%0d]: op=%0d a=%h lat=%0d nreq=%0d wr=%b strb=%b wdata=%h res=%h flags=%b want lat=%0d strb=%b wdata=%h res=%h",
                                   i, op, a, o_lat, o_nreq, o_wr, o_strb, o_wdata, o_res,
                                   {o_adel, o_ades, o_berr}, da + dd + 2, e_strb[3:0], e_wdata, e_res);
            end
        end
    endtask

    task automatic test_flush_wait;
        bit bad;
        @(negedge clk);
        mem_req = 1; load_store_mem = 3'b100; addr_mem = 32'h4000_0000; wb_allowin = 1;
        @(negedge clk);
        data_sram_addr_ok = 1;
        @(negedge clk);
        data_sram_addr_ok = 0; flush = 1; mem_req = 0;
        @(negedge clk);
        flush = 0; bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (!mem_stall || mem_done) bad = 1;
            if (c == 2) data_sram_data_ok = 1;
            if (c < 2) @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL flush_wait_drain: stall=%b done=%b want stall=1 done=0", mem_stall, mem_done);
        end
        @(negedge clk);
        data_sram_data_ok = 0;
        checks++;
        if ({mem_stall, mem_done, data_sram_req} !== 3'b000) begin
            errors++; $display("FAIL flush_wait_idle: stall/done/req=%b want 000", {mem_stall, mem_done, data_sram_req});
        end
    endtask

    task automatic test_flush_req;
        @(negedge clk);
        mem_req = 1; load_store_mem = 3'b111; addr_mem = 32'h4000_0008; wb_allowin = 1;
        @(negedge clk);
        checks++;
        if (data_sram_req !== 1'b1) begin
            errors++; $display("FAIL flush_req_pre: req=%b want 1", data_sram_req);
        end
        flush = 1; mem_req = 0;
        @(negedge clk);
        flush = 0;
        checks++;
        if ({data_sram_req, mem_stall, mem_done} !== 3'b000) begin
            errors++; $display("FAIL flush_req_drop: req/stall/done=%b want 000", {data_sram_req, mem_stall, mem_done});
        end
        data_sram_data_ok = 1;
        @(negedge clk);
        data_sram_data_ok = 0;
        @(negedge clk);
        checks++;
        if ({data_sram_req, mem_stall, mem_done} !== 3'b000) begin
            errors++; $display("FAIL stray_data_ok: req/stall/done=%b want 000", {data_sram_req, mem_stall, mem_done});
        end
    endtask

    task automatic test_timeout;
        int nreq = 0;
        @(negedge clk);
        mem_req = 1; load_store_mem = 3'b111; addr_mem = 32'h5000_0000; wb_allowin = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (data_sram_req) nreq++;
        end
        @(negedge clk);
        checks++;
        if ({nreq, data_sram_req, bus_err, mem_done, mem_stall} !== {32'd4, 4'b0111}) begin
            errors++; $display("FAIL timeout: nreq=%0d req=%b bus_err=%b done=%b stall=%b want 4 0 1 1 1",
                               nreq, data_sram_req, bus_err, mem_done, mem_stall);
        end
        @(negedge clk);
        checks++;
        if ({bus_err, mem_done, mem_stall} !== 3'b111) begin
            errors++; $display("FAIL done_hold: bus_err/done/stall=%b want 111", {bus_err, mem_done, mem_stall});
        end
        wb_allowin = 1; mem_req = 0;
        @(negedge clk);
        checks++;
        if ({bus_err, mem_done, mem_stall} !== 3'b000) begin
            errors++; $display("FAIL done_release: bus_err/done/stall=%b want 000", {bus_err, mem_done, mem_stall});
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        mem_req = 1; load_store_mem = 3'b110; addr_mem = 32'h6000_0002; rdata2_mem = 32'h1111_2222;
        @(negedge clk);
        #2 rst = 1; mem_req = 0;
        #1;
        checks++;
        if ({data_sram_req, mem_stall, mem_done, data_sram_wstrb, data_sram_addr} !== '0) begin
            errors++; $display("FAIL async_reset: req=%b stall=%b strb=%b addr=%h want all 0",
                               data_sram_req, mem_stall, data_sram_wstrb, data_sram_addr);
        end
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        test_reset;
        test_store_shaping;
        test_load_extract;
        test_misaligned;
        test_random;
        test_flush_wait;
        test_flush_req;
        test_timeout;
        test_async_reset;
        do_op(3'b010, 32'h7000_0002, 32'h0, 32'h8001_0000, 0, 1);
        checks++;
        if (o_res !== 32'hFFFF_8001) begin
            errors++; $display("FAIL lh_after_reset: res=%h want ffff8001", o_res);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
